// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared defaults and operand-select encodings for the hazard unit
package hazard_unit_pkg;
    localparam int REG_AW_DEF = 5;
    localparam int SEL_RF = 0;
    function automatic int sel_cmp(input int nfwd);
        return nfwd + 1;
    endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: IDU/pipeline-side signal bundle of the hazard unit
interface hazard_unit_if import hazard_unit_pkg::*; #(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NFWD    = 2,
    parameter int MAX_OUT = 4
);
    localparam int SW = $clog2(NFWD + 2);
    localparam int OW = $clog2(MAX_OUT + 1);
    logic                   id_valid;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_rs1_use;
    logic                   id_rs2_use;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_long;
    logic [NFWD*REG_AW-1:0] fwd_rd;
    logic [NFWD-1:0]        fwd_wen;
    logic [NFWD-1:0]        fwd_rdy;
    logic                   cmp_valid;
    logic [REG_AW-1:0]      cmp_rd;
    logic [SW-1:0]          rs1_sel;
    logic [SW-1:0]          rs2_sel;
    logic                   stall;
    logic [OW-1:0]          outstanding;
    logic [31:0]            stall_cnt;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_long,
               fwd_rd, fwd_wen, fwd_rdy, cmp_valid, cmp_rd,
        input  rs1_sel, rs2_sel, stall, outstanding, stall_cnt
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_long,
               fwd_rd, fwd_wen, fwd_rdy, cmp_valid, cmp_rd,
        output rs1_sel, rs2_sel, stall, outstanding, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: busy bits and outstanding count of long-latency register writes
module hazard_scoreboard import hazard_unit_pkg::*; #(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MAX_OUT = 4,
    localparam int OW     = $clog2(MAX_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic                     cmp_valid,
    input  logic [REG_AW-1:0]        cmp_rd,
    output logic [(1<<REG_AW)-1:0]   busy,
    output logic [OW-1:0]            outstanding
);
    logic                   clr;
    logic [(1<<REG_AW)-1:0] busy_nxt;
    assign clr = cmp_valid && busy[cmp_rd];
    // completion clears first so a same-rd reissue leaves the bit set
    always_comb begin
        busy_nxt = busy;
        if (clr) busy_nxt[cmp_rd] = 1'b0;
        if (issue) busy_nxt[issue_rd] = 1'b1;
    end
    // count moves only when exactly one of issue / effective completion happens
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy        <= busy_nxt;
            outstanding <= (issue && !clr) ? outstanding + 1'b1 :
                           (clr && !issue) ? outstanding - 1'b1 : outstanding;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding select and IDU stall from pipeline stages and scoreboard
module hazard_unit import hazard_unit_pkg::*; #(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NFWD       = 2,
    parameter int MAX_OUT    = 4,
    parameter int CMP_BYPASS = 1
) (
    input logic         clk,
    input logic         rst_n,
    hazard_unit_if.slave bus
);
    localparam int SW = $clog2(NFWD + 2);
    localparam int OW = $clog2(MAX_OUT + 1);
    logic [(1<<REG_AW)-1:0] busy;
    logic [OW-1:0]          outstanding;
    logic                   cmp_eff, waw, full, stall, issue;
    logic [31:0]            stall_cnt;
    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [REG_AW-1:0] rs;
        logic              en, hit, rdy, byp, haz;
        logic [SW-1:0]     ksel, sel;
        assign rs = (s == 0) ? bus.id_rs1 : bus.id_rs2;
        assign en = ((s == 0) ? bus.id_rs1_use : bus.id_rs2_use) && rs != '0;
        // scan oldest to youngest so the youngest matching writer wins
        always_comb begin
            hit  = 1'b0;
            rdy  = 1'b0;
            ksel = '0;
            for (int k = NFWD; k >= 1; k--)
                if (bus.fwd_wen[k-1] && bus.fwd_rd[k*REG_AW-1 -: REG_AW] == rs) begin
                    hit  = 1'b1;
                    rdy  = bus.fwd_rdy[k-1];
                    ksel = SW'(k);
                end
        end
        assign byp = CMP_BYPASS != 0 && bus.cmp_valid && bus.cmp_rd == rs;
        assign sel = !en ? SW'(SEL_RF) :
                     hit ? (rdy ? ksel : SW'(SEL_RF)) :
                     (busy[rs] && byp) ? SW'(sel_cmp(NFWD)) : SW'(SEL_RF);
        assign haz = en && (hit ? !rdy : busy[rs] && !byp);
    end
    assign cmp_eff = CMP_BYPASS != 0 && bus.cmp_valid && busy[bus.cmp_rd];
    assign waw     = bus.id_long && busy[bus.id_rd] && !(cmp_eff && bus.cmp_rd == bus.id_rd);
    assign full    = bus.id_long && outstanding == OW'(MAX_OUT) && !cmp_eff;
    assign stall   = bus.id_valid && (g_src[0].haz || g_src[1].haz || waw || full);
    assign issue   = bus.id_valid && bus.id_long && !stall && bus.id_rd != '0;
    hazard_scoreboard #(.REG_AW(REG_AW), .MAX_OUT(MAX_OUT)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_rd   (bus.id_rd),
        .cmp_valid  (bus.cmp_valid),
        .cmp_rd     (bus.cmp_rd),
        .busy       (busy),
        .outstanding(outstanding)
    );
    // saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt <= '0;
        else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
    assign bus.rs1_sel     = g_src[0].sel;
    assign bus.rs2_sel     = g_src[1].sel;
    assign bus.stall       = stall;
    assign bus.outstanding = outstanding;
    assign bus.stall_cnt   = stall_cnt;
endmodule
